// File: rtl/synth_pkg.sv
// Shared sizing and FSM encoding for the voice phase accumulator.
// Imported by the interface, the phase store and the top.
package synth_pkg;
   localparam int VOICES    = 32;
   localparam int VOICE_W   = 5;
   localparam int CONST_W   = 24;
   localparam int PHASE_W   = 32;
   localparam int CONST_LAT = 1;
   localparam int NOTE_W    = 9;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN
   } state_e;
endpackage

// File: rtl/voice_phase_acc_if.sv
// Key command bus and phase output stream of the accumulator.
// master = accumulator side, slave = controller / lookup side.
interface voice_phase_acc_if;
   import synth_pkg::*;

   logic               key_on;
   logic               key_off;
   logic [VOICE_W-1:0] key_voice;
   logic [NOTE_W-1:0]  key_note;
   logic               key_sync;

   logic [PHASE_W-1:0] phase_out;
   logic [VOICE_W-1:0] phase_voice;
   logic               phase_gate;
   logic               phase_valid;

   modport master (
      input  key_on, key_off, key_voice, key_note, key_sync,
      output phase_out, phase_voice, phase_gate, phase_valid
   );

   modport slave (
      output key_on, key_off, key_voice, key_note, key_sync,
      input  phase_out, phase_voice, phase_gate, phase_valid
   );
endinterface

// File: rtl/voice_phase_ram.sv
// Per-voice phase store: one combinational read port,
// one synchronous write port, no reset (cleared via flags).
module voice_phase_ram
   import synth_pkg::*;
(
   input  logic               clk,
   input  logic               we,
   input  logic [VOICE_W-1:0] waddr,
   input  logic [PHASE_W-1:0] wdata,
   input  logic [VOICE_W-1:0] raddr,
   output logic [PHASE_W-1:0] rdata
);
   logic [PHASE_W-1:0] mem_q [VOICES];

   // write-back of the accumulated phase
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/voice_phase_acc.sv
// Time-multiplexed phase accumulator: scans all voices per
// sample_tick, adds the mapped increment, streams the result.
module voice_phase_acc
   import synth_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               sample_tick,
   output logic [NOTE_W-1:0]  sound,
   input  logic [CONST_W-1:0] constant,
   output logic               busy,
   output logic               overrun,
   voice_phase_acc_if.master  vif
);
   state_e             state_q, state_d;
   logic [VOICE_W-1:0] v_q, v_d;
   logic               overrun_q, overrun_d;
   logic               s1_valid_q, s1_valid_d;
   logic [VOICE_W-1:0] s1_voice_q, s1_voice_d;
   logic [PHASE_W-1:0] phase_out_q, phase_out_d;
   logic [VOICE_W-1:0] phase_voice_q, phase_voice_d;
   logic               phase_gate_q, phase_gate_d;
   logic               phase_valid_q, phase_valid_d;
   logic [NOTE_W-1:0]  note_q [VOICES];
   logic [NOTE_W-1:0]  note_d [VOICES];
   logic [VOICES-1:0]  gate_q, gate_d;
   logic [VOICES-1:0]  clr_q, clr_d;
   logic [PHASE_W-1:0] rd_data, base, wdata;

   voice_phase_ram u_ram (
      .clk   (clk),
      .we    (s1_valid_q),
      .waddr (s1_voice_q),
      .wdata (wdata),
      .raddr (s1_voice_q),
      .rdata (rd_data)
   );

   // scan FSM: issue one voice per clock, then drain the pipe
   always_comb begin
      state_d   = state_q;
      v_d       = v_q;
      overrun_d = overrun_q;
      unique case (state_q)
         IDLE: begin
            if (sample_tick) begin
               state_d = SCAN;
               v_d     = '0;
            end
         end
         SCAN: begin
            v_d = v_q + 1'b1;
            if (v_q == VOICE_W'(VOICES - 1)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (phase_valid_q &&
                phase_voice_q == VOICE_W'(VOICES - 1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (sample_tick && state_q != IDLE) begin
         overrun_d = 1'b1;
      end
   end

   // a pending clear makes the stored phase read as zero
   assign base = clr_q[s1_voice_q] ? '0 : rd_data;

   // accumulate stage: gated voices add the constant, others hold
   always_comb begin
      wdata = base;
      if (gate_q[s1_voice_q]) begin
         wdata = base + PHASE_W'(constant);
      end
      s1_valid_d    = (state_q == SCAN);
      s1_voice_d    = v_q;
      phase_valid_d = s1_valid_q;
      phase_out_d   = phase_out_q;
      phase_voice_d = phase_voice_q;
      phase_gate_d  = phase_gate_q;
      if (s1_valid_q) begin
         phase_out_d   = wdata;
         phase_voice_d = s1_voice_q;
         phase_gate_d  = gate_q[s1_voice_q];
      end
   end

   // key commands; a sync clear outranks the same-cycle write-back
   always_comb begin
      note_d = note_q;
      gate_d = gate_q;
      clr_d  = clr_q;
      if (s1_valid_q) begin
         clr_d[s1_voice_q] = 1'b0;
      end
      if (vif.key_on) begin
         note_d[vif.key_voice] = vif.key_note;
         gate_d[vif.key_voice] = 1'b1;
         if (vif.key_sync) begin
            clr_d[vif.key_voice] = 1'b1;
         end
      end
      if (vif.key_off) begin
         gate_d[vif.key_voice] = 1'b0;
      end
   end

   // state registers; reset marks every phase as cleared
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         v_q           <= '0;
         overrun_q     <= 1'b0;
         s1_valid_q    <= 1'b0;
         s1_voice_q    <= '0;
         phase_out_q   <= '0;
         phase_voice_q <= '0;
         phase_gate_q  <= 1'b0;
         phase_valid_q <= 1'b0;
         note_q        <= '{default: '0};
         gate_q        <= '0;
         clr_q         <= '1;
      end else begin
         state_q       <= state_d;
         v_q           <= v_d;
         overrun_q     <= overrun_d;
         s1_valid_q    <= s1_valid_d;
         s1_voice_q    <= s1_voice_d;
         phase_out_q   <= phase_out_d;
         phase_voice_q <= phase_voice_d;
         phase_gate_q  <= phase_gate_d;
         phase_valid_q <= phase_valid_d;
         note_q        <= note_d;
         gate_q        <= gate_d;
         clr_q         <= clr_d;
      end
   end

   assign sound = (state_q == SCAN) ? note_q[v_q] : '0;
   assign busy  = (state_q != IDLE);
   assign overrun = overrun_q;

   assign vif.phase_out   = phase_out_q;
   assign vif.phase_voice = phase_voice_q;
   assign vif.phase_gate  = phase_gate_q;
   assign vif.phase_valid = phase_valid_q;
endmodule

// File: tb/tb_voice_phase_acc.sv
// Bench for voice_phase_acc: per-voice model, registered map
// constant = sound*256+1 (with override), stream scoreboard.
module tb_voice_phase_acc;
   import synth_pkg::*;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               sample_tick = 1'b0;
   logic [NOTE_W-1:0]  sound;
   logic [CONST_W-1:0] constant = '0;
   logic               busy;
   logic               overrun;

   voice_phase_acc_if vif ();

   voice_phase_acc dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sample_tick (sample_tick),
      .sound       (sound),
      .constant    (constant),
      .busy        (busy),
      .overrun     (overrun),
      .vif         (vif)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic               ovr_en = 1'b0;
   logic [CONST_W-1:0] ovr_val = '0;

   logic [NOTE_W-1:0]  m_note  [VOICES];
   logic               m_gate  [VOICES];
   logic [PHASE_W-1:0] m_phase [VOICES];
   logic [PHASE_W-1:0] obs_phase [VOICES];
   logic               obs_gate  [VOICES];

   typedef struct packed {
      logic [VOICE_W-1:0] v;
      logic [PHASE_W-1:0] p;
      logic               g;
   } exp_t;
   exp_t exp_q [$];

   logic               inj_on = 1'b0;
   logic               inj_off = 1'b0;
   logic [VOICE_W-1:0] inj_v = '0;
   logic [NOTE_W-1:0]  inj_n = '0;
   logic               inj_sync = 1'b0;

   function automatic logic [CONST_W-1:0] map_fn(
      input logic [NOTE_W-1:0] s);
      if (ovr_en && s == '0) return ovr_val;
      return CONST_W'(s) * CONST_W'(256) + CONST_W'(1);
   endfunction

   always @(posedge clk) constant <= map_fn(sound);

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : compare
      exp_t e;
      if (reset_n && vif.phase_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_extra: got voice %0d want none",
                     vif.phase_voice);
         end else begin
            e = exp_q.pop_front();
            chk("stream_voice", 64'(vif.phase_voice), 64'(e.v));
            chk("stream_phase", 64'(vif.phase_out), 64'(e.p));
            chk("stream_gate", 64'(vif.phase_gate), 64'(e.g));
            obs_phase[vif.phase_voice] = vif.phase_out;
            obs_gate[vif.phase_voice]  = vif.phase_gate;
         end
      end
   end

   task automatic model_reset();
      for (int v = 0; v < VOICES; v++) begin
         m_note[v]    = '0;
         m_gate[v]    = 1'b0;
         m_phase[v]   = '0;
         obs_phase[v] = '1;
         obs_gate[v]  = 1'b1;
      end
      exp_q.delete();
   endtask

   task automatic model_scan();
      exp_t e;
      for (int v = 0; v < VOICES; v++) begin
         if (m_gate[v])
            m_phase[v] = m_phase[v] + PHASE_W'(map_fn(m_note[v]));
         e.v = VOICE_W'(v);
         e.p = m_phase[v];
         e.g = m_gate[v];
         exp_q.push_back(e);
      end
   endtask

   task automatic model_key(input logic on, input logic off,
                            input logic [VOICE_W-1:0] v,
                            input logic [NOTE_W-1:0] n,
                            input logic sync);
      if (on) begin
         m_note[v] = n;
         m_gate[v] = 1'b1;
         if (sync) m_phase[v] = '0;
      end
      if (off) m_gate[v] = 1'b0;
   endtask

   task automatic drive_key(input logic on, input logic off,
                            input logic [VOICE_W-1:0] v,
                            input logic [NOTE_W-1:0] n,
                            input logic sync);
      vif.key_on    = on;
      vif.key_off   = off;
      vif.key_voice = v;
      vif.key_note  = n;
      vif.key_sync  = sync;
   endtask

   task automatic key_pulse(input logic on, input logic off,
                            input logic [VOICE_W-1:0] v,
                            input logic [NOTE_W-1:0] n,
                            input logic sync);
      @(negedge clk);
      drive_key(on, off, v, n, sync);
      model_key(on, off, v, n, sync);
      @(negedge clk);
      drive_key(1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic run_scan(input int tick_at, input int key_at);
      int n;
      int first;
      int cnt;
      @(negedge clk);
      sample_tick = 1'b1;
      model_scan();
      @(negedge clk);
      sample_tick = 1'b0;
      n = 0;
      first = -1;
      cnt = 0;
      while (busy && n < 100) begin
         if (vif.phase_valid) begin
            if (first < 0) first = n;
            cnt++;
         end
         sample_tick = (n == tick_at);
         if (n == key_at) begin
            drive_key(inj_on, inj_off, inj_v, inj_n, inj_sync);
            model_key(inj_on, inj_off, inj_v, inj_n, inj_sync);
         end else begin
            drive_key(1'b0, 1'b0, '0, '0, 1'b0);
         end
         n++;
         @(negedge clk);
      end
      sample_tick = 1'b0;
      drive_key(1'b0, 1'b0, '0, '0, 1'b0);
      chk("scan_len", 64'(n), 64'(34));
      chk("first_valid_at", 64'(first), 64'(2));
      chk("valid_count", 64'(cnt), 64'(32));
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_sound"}, 64'(sound), 64'(0));
      chk({tag, "_phase_out"}, 64'(vif.phase_out), 64'(0));
      chk({tag, "_phase_voice"}, 64'(vif.phase_voice), 64'(0));
      chk({tag, "_phase_gate"}, 64'(vif.phase_gate), 64'(0));
      chk({tag, "_phase_valid"}, 64'(vif.phase_valid), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_overrun"}, 64'(overrun), 64'(0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drive_key(1'b0, 1'b0, '0, '0, 1'b0);
      model_reset();
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      reset_n = 1'b1;
      @(negedge clk);
      chk_idle_outputs("after_reset");

      run_scan(-1, -1);
      chk("v0_zero", 64'(obs_phase[0]), 64'(0));
      chk("v31_gate0", 64'(obs_gate[31]), 64'(0));

      key_pulse(1'b1, 1'b0, 5'd3, 9'd69, 1'b0);
      run_scan(-1, -1);
      chk("v3_tick1", 64'(obs_phase[3]), 64'(17665));
      run_scan(-1, -1);
      chk("v3_tick2", 64'(obs_phase[3]), 64'(35330));
      run_scan(-1, -1);
      chk("v3_tick3", 64'(obs_phase[3]), 64'(52995));
      chk("v4_still0", 64'(obs_phase[4]), 64'(0));

      key_pulse(1'b1, 1'b0, 5'd5, 9'd0, 1'b0);
      ovr_en  = 1'b1;
      ovr_val = 24'hFF_FFFF;
      for (int i = 0; i < 256; i++) run_scan(-1, -1);
      chk("v5_preload", 64'(obs_phase[5]), 64'hFFFF_FF00);
      ovr_en = 1'b0;
      run_scan(-1, -1);
      chk("v5_plus1", 64'(obs_phase[5]), 64'hFFFF_FF01);
      ovr_en  = 1'b1;
      ovr_val = 24'h00_00FF;
      run_scan(-1, -1);
      chk("v5_wrap", 64'(obs_phase[5]), 64'h0000_0000);
      ovr_en = 1'b0;

      chk("overrun_before", 64'(overrun), 64'(0));
      run_scan(10, -1);
      chk("overrun_mid", 64'(overrun), 64'(1));
      run_scan(33, -1);
      repeat (3) @(negedge clk);
      chk("tick_at_drain_end_ignored", 64'(busy), 64'(0));
      run_scan(-1, -1);
      chk("overrun_sticky", 64'(overrun), 64'(1));

      key_pulse(1'b1, 1'b0, 5'd7, 9'd10, 1'b0);
      run_scan(-1, -1);
      chk("v7_base", 64'(obs_phase[7]), 64'(2561));
      inj_on   = 1'b1;
      inj_off  = 1'b0;
      inj_v    = 5'd7;
      inj_n    = 9'd20;
      inj_sync = 1'b1;
      run_scan(-1, 8);
      chk("v7_inflight_out", 64'(obs_phase[7]), 64'(5122));
      run_scan(-1, -1);
      chk("v7_synced", 64'(obs_phase[7]), 64'(5121));

      key_pulse(1'b1, 1'b1, 5'd9, 9'd33, 1'b0);
      run_scan(-1, -1);
      chk("v9_off_wins", 64'(obs_gate[9]), 64'(0));
      chk("v9_held", 64'(obs_phase[9]), 64'(0));
      key_pulse(1'b1, 1'b0, 5'd9, 9'd33, 1'b0);
      run_scan(-1, -1);
      chk("v9_note_loaded", 64'(obs_phase[9]), 64'(8449));

      @(negedge clk);
      sample_tick = 1'b1;
      model_scan();
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(vif.phase_valid), 64'(0));
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_overrun", 64'(overrun), 64'(0));
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_scan(-1, -1);
      chk("v3_after_rst", 64'(obs_phase[3]), 64'(0));
      chk("v5_gate_after_rst", 64'(obs_gate[5]), 64'(0));
      chk("overrun_after_rst", 64'(overrun), 64'(0));

      repeat (3) @(negedge clk);
      chk("stream_left", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
